// File: rtl/nic8_ctl_pkg.sv
// nic8_ctl_pkg
// Shared types and constants for the nic8 run/halt/single-step controller.
//   ctl_state_t  : sequencer states
//   ctl_op_t     : host command opcodes carried on cmdOp
//   halt_cause_t : encoding reported on haltCause
//   CYCLES_MAX   : saturation value of the enabled-cycle counter
package nic8_ctl_pkg;

  typedef enum logic [1:0] {
    ST_HALTED   = 2'd0,
    ST_RUNNING  = 2'd1,
    ST_STEPPING = 2'd2,
    ST_STOPPING = 2'd3
  } ctl_state_t;

  typedef enum logic [1:0] {
    OP_NOP  = 2'd0,
    OP_RUN  = 2'd1,
    OP_HALT = 2'd2,
    OP_STEP = 2'd3
  } ctl_op_t;

  typedef enum logic [1:0] {
    CAUSE_RESET = 2'd0,
    CAUSE_HOST  = 2'd1,
    CAUSE_STEP  = 2'd2,
    CAUSE_BRK   = 2'd3
  } halt_cause_t;

  localparam logic [15:0] CYCLES_MAX = 16'hFFFF;

endpackage

// File: rtl/step_control_break_match.sv
// break_match
// Purely combinational breakpoint comparator; only instantiated when
// STEP_CONTROL_BREAKPOINT_EN is defined.
// Ports:
//   brkEn   in  1  breakpoint armed
//   pc      in  8  CPU program counter
//   brkAddr in  8  breakpoint address
//   hit     out 1  armed and pc equals brkAddr
module break_match (
  input  logic       brkEn,
  input  logic [7:0] pc,
  input  logic [7:0] brkAddr,
  output logic       hit
);

  assign hit = brkEn && (pc == brkAddr);

endmodule

// File: rtl/step_control.sv
// step_control
// Run/halt/single-step sequencer for the nic8 CPU. Gates the CPU clock-enable
// so the datapath only advances when commanded and always stops right after
// an instruction completes (fetch boundary).
// Configuration macro: STEP_CONTROL_BREAKPOINT_EN (defined = breakpoint
// compare active; undefined = brkEn/brkAddr ignored, haltCause never 3).
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   cmdValid/cmdReady      host command handshake (cmdReady low in STOPPING)
//   cmdOp, cmdCount        command opcode and STEP instruction count
//   instrDone, pc          CPU instruction-complete strobe and program counter
//   brkEn, brkAddr         breakpoint arm and address
//   cpuEnable              registered clock-enable to the CPU datapath
//   halted, haltCause      halt status and reason of the last halt
//   stepsLeft, runCycles   remaining steps and saturating enabled-cycle count
module step_control
  import nic8_ctl_pkg::*;
#(
  parameter int STEP_W    = 8,
  parameter bit RESET_RUN = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmdValid,
  output logic              cmdReady,
  input  logic [1:0]        cmdOp,
  input  logic [STEP_W-1:0] cmdCount,
  input  logic              instrDone,
  input  logic [7:0]        pc,
  input  logic              brkEn,
  input  logic [7:0]        brkAddr,
  output logic              cpuEnable,
  output logic              halted,
  output logic [1:0]        haltCause,
  output logic [STEP_W-1:0] stepsLeft,
  output logic [15:0]       runCycles
);

  ctl_state_t  state;
  ctl_op_t     op;
  halt_cause_t stop_cause;
  logic        accept;
  logic        done;
  logic        brk_hit;
  logic        host_stop;
  logic        step_last;
  logic        go_halt;

  assign op       = ctl_op_t'(cmdOp);
  assign cmdReady = (state != ST_STOPPING);
  assign halted   = (state == ST_HALTED);
  assign accept   = cmdValid && cmdReady;
  // instrDone only means something while the CPU is actually clocked.
  assign done     = instrDone && cpuEnable;

`ifdef STEP_CONTROL_BREAKPOINT_EN
  break_match u_break_match (
    .brkEn   (brkEn),
    .pc      (pc),
    .brkAddr (brkAddr),
    .hit     (brk_hit)
  );
`else
  logic unused_brk;
  assign unused_brk = ^{brkEn, brkAddr, pc};
  assign brk_hit    = 1'b0;
`endif

  // Decide whether the instruction finishing this cycle ends the run, and why.
  // A HALT arriving together with instrDone stops immediately instead of
  // passing through STOPPING.
  always_comb begin
    host_stop  = (state == ST_STOPPING) ||
                 (accept && (op == OP_HALT) && (state != ST_HALTED));
    step_last  = (state == ST_STEPPING) && (stepsLeft == STEP_W'(1));
    go_halt    = 1'b0;
    stop_cause = CAUSE_HOST;
    if (done) begin
      if (brk_hit) begin
        go_halt    = 1'b1;
        stop_cause = CAUSE_BRK;
      end else if (host_stop) begin
        go_halt    = 1'b1;
        stop_cause = CAUSE_HOST;
      end else if (step_last) begin
        go_halt    = 1'b1;
        stop_cause = CAUSE_STEP;
      end
    end
  end

  // Sequencer state with registered outputs. cpuEnable is registered together
  // with the state so it drops on the same edge that samples the final instrDone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RESET_RUN ? ST_RUNNING : ST_HALTED;
      cpuEnable <= RESET_RUN;
      haltCause <= CAUSE_RESET;
      stepsLeft <= '0;
      runCycles <= '0;
    end else begin
      if (cpuEnable && (runCycles != CYCLES_MAX))
        runCycles <= runCycles + 16'd1;
      if (done && (state == ST_STEPPING))
        stepsLeft <= stepsLeft - STEP_W'(1);

      if (go_halt) begin
        state     <= ST_HALTED;
        cpuEnable <= 1'b0;
        haltCause <= stop_cause;
        if (state == ST_RUNNING)
          stepsLeft <= '0;
      end else begin
        case (state)
          ST_HALTED: begin
            if (accept) begin
              if (op == OP_RUN) begin
                state     <= ST_RUNNING;
                cpuEnable <= 1'b1;
                runCycles <= '0;
              end else if ((op == OP_STEP) && (cmdCount != '0)) begin
                state     <= ST_STEPPING;
                cpuEnable <= 1'b1;
                stepsLeft <= cmdCount;
                runCycles <= '0;
              end
            end
          end
          ST_RUNNING, ST_STEPPING: begin
            if (accept && (op == OP_HALT))
              state <= ST_STOPPING;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_step_control.sv
// tb_step_control
// Directed, table-driven bench for step_control plus hand-written sequences
// for run/halt timing, breakpoints, asynchronous reset and counter saturation.
// A second instance with RESET_RUN=1 shares the reset.
// Expected breakpoint behaviour follows STEP_CONTROL_BREAKPOINT_EN.
module tb_step_control;
  import nic8_ctl_pkg::*;

`ifdef STEP_CONTROL_BREAKPOINT_EN
  localparam bit BRK = 1'b1;
`else
  localparam bit BRK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmdValid = 1'b0;
  logic [1:0]  cmdOp = 2'd0;
  logic [7:0]  cmdCount = 8'd0;
  logic        instrDone = 1'b0;
  logic [7:0]  pc = 8'd0;
  logic        brkEn = 1'b0;
  logic [7:0]  brkAddr = 8'd0;
  logic        cmdReady, cpuEnable, halted;
  logic [1:0]  haltCause;
  logic [7:0]  stepsLeft;
  logic [15:0] runCycles;

  logic        r_cmdReady, r_cpuEnable, r_halted;
  logic [1:0]  r_haltCause;
  logic [7:0]  r_stepsLeft;
  logic [15:0] r_runCycles;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  step_control #(.STEP_W(8), .RESET_RUN(1'b0)) dut (
    .clk(clk), .reset(reset), .cmdValid(cmdValid), .cmdReady(cmdReady),
    .cmdOp(cmdOp), .cmdCount(cmdCount), .instrDone(instrDone), .pc(pc),
    .brkEn(brkEn), .brkAddr(brkAddr), .cpuEnable(cpuEnable), .halted(halted),
    .haltCause(haltCause), .stepsLeft(stepsLeft), .runCycles(runCycles)
  );

  step_control #(.STEP_W(8), .RESET_RUN(1'b1)) dut_run (
    .clk(clk), .reset(reset), .cmdValid(1'b0), .cmdReady(r_cmdReady),
    .cmdOp(2'd0), .cmdCount(8'd0), .instrDone(1'b0), .pc(8'd0),
    .brkEn(1'b0), .brkAddr(8'd0), .cpuEnable(r_cpuEnable), .halted(r_halted),
    .haltCause(r_haltCause), .stepsLeft(r_stepsLeft), .runCycles(r_runCycles)
  );

  typedef struct {
    logic       v;
    logic [1:0] op;
    logic [7:0] cnt;
    logic       done;
    logic       en;
    logic       hl;
    logic [1:0] cause;
    int         steps;
    logic       ready;
    int         run;
  } vec_t;

  vec_t tbl[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [7:0] cnt,
                               input logic done, input logic [7:0] pcv);
    cmdValid  = v;
    cmdOp     = op;
    cmdCount  = cnt;
    instrDone = done;
    pc        = pcv;
  endtask

  initial begin
    //           v  op cnt done en hl cause steps ready run
    tbl.push_back('{1, 0, 0, 0, 0, 1, 0, 0, 1, 0});   // NOP in HALTED
    tbl.push_back('{1, 3, 0, 0, 0, 1, 0, 0, 1, 0});   // STEP 0 ignored
    tbl.push_back('{1, 2, 0, 0, 0, 1, 0, 0, 1, 0});   // HALT in HALTED
    tbl.push_back('{0, 0, 0, 1, 0, 1, 0, 0, 1, 0});   // instrDone ignored when disabled
    tbl.push_back('{1, 3, 3, 0, 1, 0, 0, 3, 1, 0});   // STEP 3
    tbl.push_back('{0, 0, 0, 0, 1, 0, 0, 3, 1, 1});
    tbl.push_back('{0, 0, 0, 1, 1, 0, 0, 2, 1, 2});
    tbl.push_back('{1, 1, 0, 0, 1, 0, 0, 2, 1, 3});   // RUN ignored while stepping
    tbl.push_back('{0, 0, 0, 1, 1, 0, 0, 1, 1, 4});
    tbl.push_back('{0, 0, 0, 0, 1, 0, 0, 1, 1, 5});
    tbl.push_back('{0, 0, 0, 1, 0, 1, 2, 0, 1, 6});   // step exhausted
    tbl.push_back('{0, 0, 0, 0, 0, 1, 2, 0, 1, 6});
    tbl.push_back('{1, 3, 0, 0, 0, 1, 2, 0, 1, 6});   // STEP 0 keeps cause
    tbl.push_back('{1, 1, 0, 0, 1, 0, 2, 0, 1, 0});   // RUN clears runCycles
    tbl.push_back('{0, 0, 0, 1, 1, 0, 2, 0, 1, 1});
    tbl.push_back('{1, 2, 0, 0, 1, 0, 2, 0, 0, 2});   // HALT -> STOPPING
    tbl.push_back('{1, 1, 0, 0, 1, 0, 2, 0, 0, 3});   // not accepted in STOPPING
    tbl.push_back('{0, 0, 0, 1, 0, 1, 1, 0, 1, 4});   // host halt at boundary
    tbl.push_back('{1, 1, 0, 1, 1, 0, 1, 0, 1, 0});   // RUN; stray instrDone ignored
    tbl.push_back('{1, 2, 0, 1, 0, 1, 1, 0, 1, 1});   // HALT with instrDone same cycle
    tbl.push_back('{1, 3, 5, 0, 1, 0, 1, 5, 1, 0});   // STEP 5
    tbl.push_back('{0, 0, 0, 1, 1, 0, 1, 4, 1, 1});
    tbl.push_back('{1, 2, 0, 0, 1, 0, 1, 4, 0, 2});   // HALT while stepping
    tbl.push_back('{0, 0, 0, 1, 0, 1, 1, -1, 1, 3});

    // Reset values
    tick();
    tick();
    checkOutput("rst.cpuEnable", 32'(cpuEnable), 0);
    checkOutput("rst.halted", 32'(halted), 1);
    checkOutput("rst_run.cpuEnable", 32'(r_cpuEnable), 1);
    reset = 1'b0;
    tick();
    checkOutput("rst.haltCause", 32'(haltCause), 0);
    checkOutput("rst.stepsLeft", 32'(stepsLeft), 0);
    checkOutput("rst.runCycles", 32'(runCycles), 0);
    checkOutput("rst.cmdReady", 32'(cmdReady), 1);

    // Table-driven vectors
    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i].v, tbl[i].op, tbl[i].cnt, tbl[i].done, 8'h00);
      tick();
      checkOutput($sformatf("v%0d.cpuEnable", i), 32'(cpuEnable), 32'(tbl[i].en));
      checkOutput($sformatf("v%0d.halted", i), 32'(halted), 32'(tbl[i].hl));
      checkOutput($sformatf("v%0d.haltCause", i), 32'(haltCause), 32'(tbl[i].cause));
      checkOutput($sformatf("v%0d.cmdReady", i), 32'(cmdReady), 32'(tbl[i].ready));
      checkOutput($sformatf("v%0d.runCycles", i), 32'(runCycles), 32'(tbl[i].run));
      if (tbl[i].steps >= 0)
        checkOutput($sformatf("v%0d.stepsLeft", i), 32'(stepsLeft), 32'(tbl[i].steps));
    end

    // RUN, instrDone every 3 cycles, HALT after 10 cycles
    applyStimulus(1, 2'd1, 0, 0, 8'h00);
    tick();
    for (int k = 1; k <= 12; k++) begin
      applyStimulus(k == 10, 2'd2, 0, (k % 3) == 0, 8'h00);
      tick();
      if (k == 11) begin
        checkOutput("seqA.en_k11", 32'(cpuEnable), 1);
        checkOutput("seqA.ready_k11", 32'(cmdReady), 0);
      end
    end
    checkOutput("seqA.cpuEnable", 32'(cpuEnable), 0);
    checkOutput("seqA.haltCause", 32'(haltCause), 1);
    checkOutput("seqA.runCycles", 32'(runCycles), 12);

    // Breakpoint
    brkEn   = 1'b1;
    brkAddr = 8'h12;
    applyStimulus(1, 2'd1, 0, 0, 8'h00);
    tick();
    applyStimulus(0, 2'd0, 0, 1, 8'h10);
    tick();
    checkOutput("brk.miss_halted", 32'(halted), 0);
    applyStimulus(0, 2'd0, 0, 1, 8'h12);
    tick();
    checkOutput("brk.hit_halted", 32'(halted), 32'(BRK));
    checkOutput("brk.hit_cpuEnable", 32'(cpuEnable), 32'(!BRK));
    applyStimulus(1, 2'd2, 0, 1, 8'h00);
    tick();
    checkOutput("brk.cleanup_halted", 32'(halted), 1);
    checkOutput("brk.cleanup_cause", 32'(haltCause), BRK ? 3 : 1);
    applyStimulus(1, 2'd1, 0, 0, 8'h00);
    tick();
    applyStimulus(1, 2'd2, 0, 1, 8'h12);
    tick();
    checkOutput("brk.halt_same_halted", 32'(halted), 1);
    checkOutput("brk.halt_same_cause", 32'(haltCause), BRK ? 3 : 1);
    brkEn = 1'b0;

    // Asynchronous reset mid-STEPPING
    applyStimulus(1, 2'd3, 8'd5, 0, 8'h00);
    tick();
    applyStimulus(0, 2'd0, 0, 0, 8'h00);
    checkOutput("arst.pre_steps", 32'(stepsLeft), 5);
    #3 reset = 1'b1;
    #1;
    checkOutput("arst.cpuEnable", 32'(cpuEnable), 0);
    checkOutput("arst.halted", 32'(halted), 1);
    checkOutput("arst.haltCause", 32'(haltCause), 0);
    checkOutput("arst.stepsLeft", 32'(stepsLeft), 0);
    checkOutput("arst.runCycles", 32'(runCycles), 0);
    tick();
    reset = 1'b0;
    tick();
    checkOutput("arst.post_halted", 32'(halted), 1);
    checkOutput("rst_run.post_cpuEnable", 32'(r_cpuEnable), 1);
    checkOutput("rst_run.post_halted", 32'(r_halted), 0);

    // runCycles saturation
    applyStimulus(1, 2'd1, 0, 0, 8'h00);
    tick();
    checkOutput("sat.start", 32'(runCycles), 0);
    applyStimulus(0, 2'd0, 0, 0, 8'h00);
    repeat (65540) tick();
    checkOutput("sat.max", 32'(runCycles), 32'hFFFF);
    applyStimulus(1, 2'd2, 0, 1, 8'h00);
    tick();
    checkOutput("sat.halted", 32'(halted), 1);
    checkOutput("sat.hold", 32'(runCycles), 32'hFFFF);
    applyStimulus(1, 2'd1, 0, 0, 8'h00);
    tick();
    checkOutput("sat.clear", 32'(runCycles), 0);
    applyStimulus(0, 2'd0, 0, 0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
